// File: rtl/timer_pkg.sv
// Shared constants for the timer control path: default timing, counter widths,
// mode encoding and the start-key hold state encoding.
package timer_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 32'd1000000;
  localparam int unsigned HOLD_CYCLES_DEF     = 32'd100000000;
  localparam int unsigned DEB_CNT_W           = $clog2(DEBOUNCE_CYCLES_DEF);
  localparam int unsigned HOLD_CNT_W          = $clog2(HOLD_CYCLES_DEF);

  localparam logic MODE_STOPWATCH = 1'b0;
  localparam logic MODE_TIMER     = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } start_state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchronizer, stability-count debounce and
// one-clock press (stable 1->0) / release (stable 0->1) strobes.
module key_debounce
  import timer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic pressed_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             press_q;
  logic             release_q;

  // Accept the synced level only after it has differed from stable for DEBOUNCE_CYCLES clocks.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = {CNT_W{1'b0}};
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        cnt_d    = {CNT_W{1'b0}};
      end else begin
        cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      stable_q  <= 1'b1;
      cnt_q     <= {CNT_W{1'b0}};
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= key_ni;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      press_q   <= stable_q & ~stable_d;
      release_q <= ~stable_q & stable_d;
    end
  end

  assign pressed_o = ~stable_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/button_conditioner.sv
// Start/stop and mode push-button conditioning for the timer core.
// Optional HOLD_CLEAR_EN: start toggles on short-press release; a long hold pulses Clear.
module button_conditioner
  import timer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEF
) (
  input  logic CLK_50MHz,
  input  logic rst_n,
  input  logic KeyStartStop_n,
  input  logic KeyMode_n,
  output logic StartStop,
  output logic ModeSel,
  output logic ModeChg,
  output logic Clear
);

  logic ss_pressed_s;
  logic ss_press_s;
  logic ss_release_s;
  logic md_pressed_unused_s;
  logic md_press_s;
  logic md_release_unused_s;

  logic run_q;
  logic mode_q;
  logic mode_chg_q;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_start (
    .clk_i     (CLK_50MHz),
    .rst_ni    (rst_n),
    .key_ni    (KeyStartStop_n),
    .pressed_o (ss_pressed_s),
    .press_o   (ss_press_s),
    .release_o (ss_release_s)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_mode (
    .clk_i     (CLK_50MHz),
    .rst_ni    (rst_n),
    .key_ni    (KeyMode_n),
    .pressed_o (md_pressed_unused_s),
    .press_o   (md_press_s),
    .release_o (md_release_unused_s)
  );

  // Mode changes only while paused; run_q is still the pre-toggle value on a simultaneous start press.
  always_ff @(posedge CLK_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_STOPWATCH;
      mode_chg_q <= 1'b0;
    end else if (md_press_s && !run_q) begin
      mode_q     <= ~mode_q;
      mode_chg_q <= 1'b1;
    end else begin
      mode_chg_q <= 1'b0;
    end
  end

`ifdef HOLD_CLEAR_EN
  localparam int unsigned       HOLD_W    = cnt_width(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 32'd1);

  start_state_e      st_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic              clear_q;
  logic              hold_unused_s;

  assign hold_unused_s = ss_pressed_s;

  // Start key: short press toggles on release, a press reaching HOLD_CYCLES clears and pauses.
  always_ff @(posedge CLK_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= ST_IDLE;
      hold_cnt_q <= {HOLD_W{1'b0}};
      run_q      <= 1'b0;
      clear_q    <= 1'b0;
    end else begin
      clear_q <= 1'b0;
      case (st_q)
        ST_IDLE: begin
          hold_cnt_q <= {HOLD_W{1'b0}};
          if (ss_press_s) begin
            st_q <= ST_PRESSED;
          end
        end
        ST_PRESSED: begin
          if (ss_release_s) begin
            run_q      <= ~run_q;
            hold_cnt_q <= {HOLD_W{1'b0}};
            st_q       <= ST_IDLE;
          end else if (hold_cnt_q == HOLD_LAST) begin
            clear_q <= 1'b1;
            run_q   <= 1'b0;
            st_q    <= ST_HELD;
          end else begin
            hold_cnt_q <= hold_cnt_q + {{(HOLD_W-1){1'b0}}, 1'b1};
          end
        end
        ST_HELD: begin
          hold_cnt_q <= {HOLD_W{1'b0}};
          if (ss_release_s) begin
            st_q <= ST_IDLE;
          end
        end
        default: begin
          st_q       <= ST_IDLE;
          hold_cnt_q <= {HOLD_W{1'b0}};
          run_q      <= 1'b0;
        end
      endcase
    end
  end

  assign Clear = clear_q;
`else
  logic hold_unused_s;

  assign hold_unused_s = ss_pressed_s | ss_release_s | (HOLD_CYCLES == 32'd0);

  // Start key toggles the run level on every accepted press.
  always_ff @(posedge CLK_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
    end else if (ss_press_s) begin
      run_q <= ~run_q;
    end else begin
      run_q <= run_q;
    end
  end

  assign Clear = 1'b0;
`endif

  assign StartStop = run_q;
  assign ModeSel   = mode_q;
  assign ModeChg   = mode_chg_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: a per-cycle reference model predicts
// the four outputs; a monitor compares them one clock at a time.
module tb_button_conditioner;

  localparam int unsigned DEB  = 4;
  localparam int unsigned HOLD = 20;

  logic clk = 1'b0;
  logic rst_n;
  logic k_ss;
  logic k_md;
  logic StartStop;
  logic ModeSel;
  logic ModeChg;
  logic Clear;

  always #5 clk = ~clk;

  button_conditioner #(.DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD)) dut (
    .CLK_50MHz      (clk),
    .rst_n          (rst_n),
    .KeyStartStop_n (k_ss),
    .KeyMode_n      (k_md),
    .StartStop      (StartStop),
    .ModeSel        (ModeSel),
    .ModeChg        (ModeChg),
    .Clear          (Clear)
  );

  typedef struct packed {
    logic ss;
    logic md;
    logic mc;
    logic clr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   mc_cnt  = 0;
  int   clr_cnt = 0;

  // Reference model state: per key [0]=start, [1]=mode
  logic m_s1[2];
  logic m_s2[2];
  logic m_stable[2];
  logic m_press[2];
  logic m_rel[2];
  bit   seen0[$];
  bit   seen1[$];
  logic m_run;
  logic m_mode;
  logic m_held;
  int   m_dur;

  function automatic bit all_differ(input bit q[$], input logic st);
    if (q.size() < int'(DEB)) return 1'b0;
    for (int i = 0; i < int'(DEB); i++) begin
      if (q[q.size() - 1 - i] == st) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_step(input logic rst_l, input logic raw_ss, input logic raw_md);
    logic run_old;
    logic mc;
    logic clr;
    logic syn;
    logic flip;
    logic raw[2];
    exp_t e;
    if (!rst_l) begin
      for (int k = 0; k < 2; k++) begin
        m_s1[k] = 1'b1; m_s2[k] = 1'b1; m_stable[k] = 1'b1;
        m_press[k] = 1'b0; m_rel[k] = 1'b0;
      end
      seen0.delete(); seen1.delete();
      m_run = 1'b0; m_mode = 1'b0; m_held = 1'b0; m_dur = 0;
      e = '{ss: 1'b0, md: 1'b0, mc: 1'b0, clr: 1'b0};
      exp_q.push_back(e);
      return;
    end
    raw[0] = raw_ss;
    raw[1] = raw_md;
    run_old = m_run;
    mc = 1'b0;
    clr = 1'b0;
`ifdef HOLD_CLEAR_EN
    if (m_rel[0]) begin
      if (!m_held) m_run = ~m_run;
      m_held = 1'b0;
      m_dur = 0;
    end else if (!m_stable[0] && !m_held) begin
      m_dur++;
      if (m_dur == int'(HOLD)) begin
        clr = 1'b1; m_run = 1'b0; m_held = 1'b1;
      end
    end
`else
    if (m_press[0]) m_run = ~m_run;
`endif
    if (m_press[1] && !run_old) begin
      m_mode = ~m_mode;
      mc = 1'b1;
    end
    for (int k = 0; k < 2; k++) begin
      syn = m_s2[k];
      if (k == 0) begin
        seen0.push_back(syn);
        if (seen0.size() > int'(DEB)) void'(seen0.pop_front());
        flip = all_differ(seen0, m_stable[k]);
      end else begin
        seen1.push_back(syn);
        if (seen1.size() > int'(DEB)) void'(seen1.pop_front());
        flip = all_differ(seen1, m_stable[k]);
      end
      m_press[k] = flip && m_stable[k];
      m_rel[k]   = flip && !m_stable[k];
      if (flip) m_stable[k] = ~m_stable[k];
      m_s2[k] = m_s1[k];
      m_s1[k] = raw[k];
    end
    e = '{ss: m_run, md: m_mode, mc: mc, clr: clr};
    exp_q.push_back(e);
  endtask

  // Monitor: one expected output word per clock edge
  always @(posedge clk) begin
    #1;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL sb_empty t=%0t: got output with no expectation queued", $time);
    end else begin
      mon_e = exp_q.pop_front();
      if ({StartStop, ModeSel, ModeChg, Clear} !== mon_e) begin
        n_fail++;
        $display("FAIL sb_cycle t=%0t: got ss=%b md=%b mc=%b clr=%b, expected ss=%b md=%b mc=%b clr=%b",
                 $time, StartStop, ModeSel, ModeChg, Clear, mon_e.ss, mon_e.md, mon_e.mc, mon_e.clr);
      end
    end
  end

  task automatic chk(input string name, input int act, input int expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic cyc(input logic r_ss, input logic r_md);
    k_ss = r_ss;
    k_md = r_md;
    model_step(rst_n, r_ss, r_md);
    @(posedge clk);
    @(negedge clk);
    if (ModeChg) mc_cnt++;
    if (Clear) clr_cnt++;
  endtask

  task automatic run_n(input int n, input logic r_ss, input logic r_md);
    for (int i = 0; i < n; i++) cyc(r_ss, r_md);
  endtask

  task automatic async_reset(input int n, input logic r_ss, input logic r_md);
    rst_n = 1'b0;
    #1;
    chk("reset_immediate", int'({StartStop, ModeSel, ModeChg, Clear}), 0);
    run_n(n, r_ss, r_md);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rise;
    int len_ss;
    int len_md;
    logic r_ss;
    logic r_md;

    rst_n = 1'b0;
    k_ss  = 1'b1;
    k_md  = 1'b1;
    run_n(3, 1'b1, 1'b1);
    chk("reset_state", int'({StartStop, ModeSel, ModeChg, Clear}), 0);
    rst_n = 1'b1;
    run_n(3, 1'b1, 1'b1);

    // Glitches shorter than the debounce window
    mc_cnt = 0;
    run_n(3, 1'b0, 1'b1);
    run_n(10, 1'b1, 1'b1);
    run_n(3, 1'b1, 1'b0);
    run_n(10, 1'b1, 1'b1);
    chk("glitch_ss", int'(StartStop), 0);
    chk("glitch_md", int'(ModeSel), 0);
    chk("glitch_mc", mc_cnt, 0);

`ifdef HOLD_CLEAR_EN
    run_n(8, 1'b0, 1'b1);
    run_n(8, 1'b1, 1'b1);
    chk("hold_short_toggle", int'(StartStop), 1);
    clr_cnt = 0;
    run_n(30, 1'b0, 1'b1);
    chk("hold_clear_pulse", clr_cnt, 1);
    chk("hold_forced_pause", int'(StartStop), 0);
    run_n(10, 1'b1, 1'b1);
    chk("hold_release_no_toggle", int'(StartStop), 0);
    chk("hold_clear_once", clr_cnt, 1);
    run_n(10, 1'b0, 1'b1);
    run_n(10, 1'b1, 1'b1);
    chk("hold_10_toggle", int'(StartStop), 1);
`else
    rise = -1;
    for (int i = 1; i <= 10; i++) begin
      cyc(1'b0, 1'b1);
      if (rise < 0 && StartStop) rise = i;
    end
    chk("start_latency", rise, 7);
    run_n(20, 1'b0, 1'b1);
    chk("held_no_repeat", int'(StartStop), 1);
    run_n(10, 1'b1, 1'b1);
    chk("release_no_toggle", int'(StartStop), 1);

    mc_cnt = 0;
    run_n(8, 1'b1, 1'b0);
    run_n(8, 1'b1, 1'b1);
    chk("mode_ignored_running", int'(ModeSel), 0);
    chk("mode_ignored_mc", mc_cnt, 0);

    run_n(8, 1'b0, 1'b1);
    run_n(8, 1'b1, 1'b1);
    chk("pause", int'(StartStop), 0);
    mc_cnt = 0;
    run_n(8, 1'b1, 1'b0);
    run_n(8, 1'b1, 1'b1);
    chk("mode_toggle", int'(ModeSel), 1);
    chk("mode_chg_single", mc_cnt, 1);
    chk("mode_keeps_pause", int'(StartStop), 0);

    run_n(8, 1'b0, 1'b0);
    run_n(8, 1'b1, 1'b1);
    chk("both_paused_ss", int'(StartStop), 1);
    chk("both_paused_md", int'(ModeSel), 0);
    run_n(8, 1'b0, 1'b0);
    run_n(8, 1'b1, 1'b1);
    chk("both_running_ss", int'(StartStop), 0);
    chk("both_running_md", int'(ModeSel), 0);
`endif

    // Random key activity, checked cycle by cycle by the scoreboard
    r_ss = 1'b1; r_md = 1'b1; len_ss = 0; len_md = 0;
    for (int i = 0; i < 1500; i++) begin
      if (len_ss == 0) begin r_ss = ~r_ss; len_ss = int'($urandom_range(1, 30)); end
      if (len_md == 0) begin r_md = ~r_md; len_md = int'($urandom_range(1, 12)); end
      len_ss--;
      len_md--;
      cyc(r_ss, r_md);
    end
    run_n(12, 1'b1, 1'b1);

    // Reset in the middle of a debounce count
    rst_n = 1'b0;
    run_n(2, 1'b1, 1'b1);
    rst_n = 1'b1;
    run_n(2, 1'b1, 1'b1);
    run_n(8, 1'b1, 1'b0);
    run_n(8, 1'b1, 1'b1);
    run_n(8, 1'b0, 1'b1);
    run_n(8, 1'b1, 1'b1);
    chk("pre_reset_ss", int'(StartStop), 1);
    chk("pre_reset_md", int'(ModeSel), 1);
    run_n(4, 1'b0, 1'b1);
    async_reset(2, 1'b0, 1'b1);
    rst_n = 1'b1;
`ifndef HOLD_CLEAR_EN
    rise = -1;
    for (int i = 1; i <= 10; i++) begin
      cyc(1'b0, 1'b1);
      if (rise < 0 && StartStop) rise = i;
    end
    chk("requalify_latency", rise, 7);
`else
    run_n(10, 1'b0, 1'b1);
`endif
    run_n(10, 1'b1, 1'b1);

    chk("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
